nibble_serial_add_ctrl: RTL and testbench

Sequencer that adds or subtracts two WIDTH-bit operands by time-sharing one 4-bit parallel adder, feeding it one nibble per clock, LSB nibble first, with the carry registered between nibbles. It sits between a requester using a start/busy/done handshake and a single instance of the team's 4-bit `parallel_adder` datapath. It trades latency for area: one adder serves any operand width.

---
 rtl/nibble_serial_add_ctrl_pkg.sv | 18 +
 rtl/nibble_serial_add_ctrl_parallel_adder.sv | 19 +
 rtl/nibble_serial_add_ctrl.sv | 131 +++++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
// Holds the FSM state encoding, the nibble width and the index-width helper.
package nibble_serial_add_ctrl_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index counter width: $clog2(n), but never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_parallel_adder.sv
// 4-bit ripple-style parallel adder: sum and carry-out of a + b + cin.
// Time-shared by the sequencer, one nibble per clock.
module parallel_adder
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             carry
);

    logic [NIB_W:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};
    assign sum   = total[NIB_W-1:0];
    assign carry = total[NIB_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Sequencer adding/subtracting two WIDTH-bit operands through one 4-bit adder,
// LSB nibble first, with the carry registered between nibbles.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned N  = WIDTH / NIB_W;
    localparam int unsigned IW = idx_width(N);

    state_t           state_q;
    state_t           state_d;
    logic [IW-1:0]    idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             accept;
    logic             step;
    logic             last;
    logic [NIB_W-1:0] nib_a;
    logic [NIB_W-1:0] nib_b;
    logic [NIB_W-1:0] add_s;
    logic             add_c;

    assign last = (idx_q == IW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Nibble select as a decoded mux so the index never drives a variable part-select.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (idx_q == IW'(i)) begin
                nib_a = a_q[i*NIB_W +: NIB_W];
                nib_b = b_q[i*NIB_W +: NIB_W];
            end
        end
    end

    parallel_adder u_adder (
        .a     (nib_a),
        .b     (nib_b),
        .cin   (carry_q),
        .sum   (add_s),
        .carry (add_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + 1, so invert B at capture and force carry-in.
            a_q     <= op_a;
            b_q     <= sub ? ~op_b : op_b;
            carry_q <= sub | cin;
            idx_q   <= '0;
        end else if (step) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (idx_q == IW'(i)) begin
                    sum_q[i*NIB_W +: NIB_W] <= add_s;
                end
            end
            carry_q <= add_c;
            idx_q   <= idx_q + 1'b1;
            if (last) begin
                cout_q <= add_c;
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed self-checking bench for nibble_serial_add_ctrl at WIDTH=16.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_nibble_serial_add_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sub;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;

    int total;
    int bad;

    nibble_serial_add_ctrl #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation with cycle-exact handshake checks; operands are
    // scrambled after accept to show they are not re-sampled.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic s,
                          input logic [15:0] exp_sum, input logic exp_cout);
        tick();
        op_a  = a;
        op_b  = b;
        cin   = c;
        sub   = s;
        start = 1'b1;
        tick();
        start = 1'b0;
        op_a  = 16'hA5A5;
        op_b  = 16'h5A5A;
        cin   = ~c;
        sub   = ~s;
        for (int k = 1; k <= 4; k++) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            tick();
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_off"}, 32'(busy), 32'd0);
        check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
        tick();
        check({tag, "_done_off"}, 32'(done), 32'd0);
        check({tag, "_sum_hold"}, 32'(sum), 32'(exp_sum));
    endtask

    initial begin
        int ndone;
        int d[3];

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;

        repeat (3) tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);

        run_op("add1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
        run_op("carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
        run_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
        run_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
        run_op("add_cin", 16'h0FFF, 16'h7000, 1'b1, 1'b0, 16'h8000, 1'b0);

        // start re-pulsed in RUN cycle 2 must be ignored
        tick();
        op_a  = 16'h1111;
        op_b  = 16'h2222;
        cin   = 1'b0;
        sub   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        op_a  = 16'hFFFF;
        op_b  = 16'hFFFF;
        sub   = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0;
        for (int k = 3; k <= 12; k++) begin
            if (done) begin
                ndone++;
                check("ign_done_cycle", 32'(k), 32'd5);
                check("ign_sum", 32'(sum), 32'h3333);
                check("ign_cout", 32'(cout), 32'd0);
            end
            tick();
        end
        check("ign_done_count", 32'(ndone), 32'd1);
        check("ign_idle", 32'(busy), 32'd0);

        // reset in RUN cycle 2 discards the operation
        tick();
        op_a  = 16'h4444;
        op_b  = 16'h4444;
        sub   = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_sum", 32'(sum), 32'd0);
        check("mrst_cout", 32'(cout), 32'd0);
        tick();
        check("mrst_stay_idle", 32'(busy), 32'd0);
        run_op("post_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0);

        // start held high: accepts every N+2 = 6 cycles, done never merges
        tick();
        op_a  = 16'h000F;
        op_b  = 16'h0001;
        cin   = 1'b1;
        sub   = 1'b0;
        start = 1'b1;
        ndone = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("hold_done_pat", 32'(done), (k % 6 == 5) ? 32'd1 : 32'd0);
            check("hold_busy_pat", 32'(busy), (k % 6 >= 1 && k % 6 <= 4) ? 32'd1 : 32'd0);
            if (done) begin
                if (ndone < 3) d[ndone] = k;
                ndone++;
                check("hold_sum", 32'(sum), 32'h0011);
                check("hold_cout", 32'(cout), 32'd0);
            end
        end
        start = 1'b0;
        check("hold_done_count", 32'(ndone), 32'd3);
        if (ndone >= 3) begin
            check("hold_gap1", 32'(d[1] - d[0]), 32'd6);
            check("hold_gap2", 32'(d[2] - d[1]), 32'd6);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
